// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } state_t;

    localparam int         BITS_PER_BYTE = 8;
    localparam logic [2:0] LAST_BIT      = 3'(BITS_PER_BYTE - 1);
    localparam logic       ACK           = 1'b0;
    localparam logic       NACK          = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input synchronisers with SCL edge and START/STOP condition detection.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in_i,
    input  logic sda_in_i,
    output logic sda_s_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign sda_s_o    = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    // SCL must be high on both samples so an SDA edge racing an SCL edge is not taken as START/STOP
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: 7-bit address match, write-byte delivery and read-byte serialisation.
// Optional read-fetch clock stretching is built when I2C_STRETCH_EN is defined.
module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
`ifdef I2C_STRETCH_EN
    input  logic       tx_ready,
`endif
    output logic       tx_req,
    output logic       busy,
    output logic       stop_det
);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       phase_q, phase_d;
    logic       rw_q, rw_d;
    logic       first_q, first_d;
    logic       busy_q, busy_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       stop_q, stop_d;
    logic       tx_req_c, begin_byte, load_byte;
    logic       sda_s, scl_rise, scl_fall, start_s, stop_s;
    logic [7:0] byte_in;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_in_i   (scl_in),
        .sda_in_i   (sda_in),
        .sda_s_o    (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_s),
        .stop_o     (stop_s)
    );

`ifdef I2C_STRETCH_EN
    logic stretch_q, stretch_d, scl_oe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stretch_q <= 1'b0;
            scl_oe_q  <= 1'b0;
        end else begin
            stretch_q <= stretch_d;
            scl_oe_q  <= stretch_q;
        end
    end

    assign scl_oe = scl_oe_q;
`else
    assign scl_oe = 1'b0;
`endif

    assign byte_in = {shift_q[6:0], sda_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        phase_d    = phase_q;
        rw_d       = rw_q;
        first_d    = first_q;
        busy_d     = busy_q;
        sda_oe_d   = sda_oe_q;
        rx_valid_d = 1'b0;
        rx_first_d = rx_first_q;
        stop_d     = 1'b0;
        tx_req_c   = 1'b0;
        begin_byte = 1'b0;
        load_byte  = 1'b0;
`ifdef I2C_STRETCH_EN
        stretch_d  = stretch_q;
`endif
        if (stop_s) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            stop_d   = 1'b1;
            phase_d  = 1'b0;
        end else if (start_s) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            phase_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d = byte_in;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (byte_in[7:1] == TGT_ADDR) begin
                            state_d = ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = byte_in[0];
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                // phase 0: first fall drives the ACK; phase 1: second fall ends the slot
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        phase_d  = 1'b1;
                        sda_oe_d = 1'b1;
                    end else begin
                        phase_d  = 1'b0;
                        sda_oe_d = 1'b0;
                        if (state_q == ADDR_ACK && rw_q) begin
                            begin_byte = 1'b1;
                        end else begin
                            state_d   = WR_DATA;
                            bit_cnt_d = '0;
                            if (state_q == ADDR_ACK) first_d = 1'b1;
                        end
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shift_d = byte_in;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = byte_in;
                        rx_valid_d = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                        state_d    = WR_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                // bit 7 went out with the load, so a zero count here means all eight are on the wire
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt_q == '0) begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        state_d  = RD_ACK;
                    end else begin
                        sda_oe_d  = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = (bit_cnt_q == LAST_BIT) ? 3'd0 : bit_cnt_q + 3'd1;
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == NACK) state_d = IDLE;
                        else               phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        phase_d    = 1'b0;
                        begin_byte = 1'b1;
                    end
                end
                default: ;
            endcase

            if (begin_byte) begin
                tx_req_c = 1'b1;
`ifdef I2C_STRETCH_EN
                if (tx_ready) load_byte = 1'b1;
                else          stretch_d = 1'b1;
`else
                load_byte = 1'b1;
`endif
            end
`ifdef I2C_STRETCH_EN
            if (stretch_q && tx_ready) begin
                load_byte = 1'b1;
                stretch_d = 1'b0;
            end
`endif
            if (load_byte) begin
                shift_d   = {tx_data[6:0], 1'b0};
                sda_oe_d  = ~tx_data[7];
                bit_cnt_d = 3'd1;
                state_d   = RD_DATA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            phase_q    <= 1'b0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            phase_q    <= phase_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            busy_q     <= busy_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            stop_q     <= stop_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign tx_req   = tx_req_c;
    assign busy     = busy_q;
    assign stop_det = stop_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bus-controller driver plus event scoreboard on rx_valid/tx_req/stop_det.
module tb_i2c_target_responder;
    import i2c_pkg::*;

    localparam int Q = 4;

    typedef enum int {EV_RX, EV_TXREQ, EV_STOP} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        logic       first;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, scl_oe, rx_valid, rx_first, tx_req, busy, stop_det;
    logic [7:0] rx_data;
`ifdef I2C_STRETCH_EN
    logic       tx_ready = 1'b1;
`endif

    wire scl_line = scl_m & ~scl_oe;
    wire sda_line = sda_m & ~sda_oe;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  oe_cycles = 0;

    always #5 clk = ~clk;

    i2c_target_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_line),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .scl_oe   (scl_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_first (rx_first),
        .tx_data  (tx_data),
`ifdef I2C_STRETCH_EN
        .tx_ready (tx_ready),
`endif
        .tx_req   (tx_req),
        .busy     (busy),
        .stop_det (stop_det)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input ev_kind_t k, input logic [7:0] d, input logic f);
        ev_t e;
        e.kind  = k;
        e.data  = d;
        e.first = f;
        exp_q.push_back(e);
    endtask

    task automatic expect_evt(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got %s, expected no event", k.name());
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            if (k == EV_RX && e.kind == EV_RX) begin
                chk("rx_data", rx_data, e.data);
                chk("rx_first", rx_first, e.first);
            end
        end
    endtask

    always @(negedge clk) begin
        if (sda_oe) oe_cycles++;
        if (rst_n) begin
            if (rx_valid) expect_evt(EV_RX);
            if (tx_req)   expect_evt(EV_TXREQ);
            if (stop_det) expect_evt(EV_STOP);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_scl_high();
        int n = 0;
        while (scl_line !== 1'b1 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (scl_line !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL scl_timeout: scl still low after %0d clks, expected release", n);
        end
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;
        cyc(Q);
        scl_m = 1'b1;
        wait_scl_high();
        cyc(2 * Q);
        #1 s = sda_line;
        scl_m = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        cyc(Q);
        scl_m = 1'b1;
        wait_scl_high();
        cyc(Q);
        sda_m = 1'b0;
        cyc(Q);
        scl_m = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        cyc(Q);
        scl_m = 1'b1;
        wait_scl_high();
        cyc(Q);
        sda_m = 1'b1;
        cyc(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(ack, s);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         oe0;

        cyc(3);
        @(negedge clk);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_stop_det", stop_det, 0);
        chk("rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        cyc(5);

        // write 0x12, 0x34
        push(EV_RX, 8'h12, 1'b1);
        push(EV_RX, 8'h34, 1'b0);
        push(EV_STOP, 8'h00, 1'b0);
        i2c_start();
        write_byte(8'hA0, ack);
        chk("wr_addr_ack", ack, ACK);
        @(negedge clk);
        chk("wr_busy", busy, 1);
        write_byte(8'h12, ack);
        chk("wr_d0_ack", ack, ACK);
        write_byte(8'h34, ack);
        chk("wr_d1_ack", ack, ACK);
        i2c_stop();
        @(negedge clk);
        chk("wr_busy_after_stop", busy, 0);

        // non-matching address
        push(EV_STOP, 8'h00, 1'b0);
        oe0 = oe_cycles;
        i2c_start();
        write_byte(8'hA2, ack);
        chk("nm_addr_ack", ack, NACK);
        write_byte(8'h55, ack);
        chk("nm_data_ack", ack, NACK);
        @(negedge clk);
        chk("nm_busy", busy, 0);
        i2c_stop();
        chk("nm_sda_oe_cycles", oe_cycles - oe0, 0);

        // read 0xC5 twice, ACK then NACK
        tx_data = 8'hC5;
        push(EV_TXREQ, 8'h00, 1'b0);
        push(EV_TXREQ, 8'h00, 1'b0);
        push(EV_STOP, 8'h00, 1'b0);
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rd_addr_ack", ack, ACK);
        read_byte(ACK, d);
        chk("rd_byte0", d, 8'hC5);
        read_byte(NACK, d);
        chk("rd_byte1", d, 8'hC5);
        @(negedge clk);
        chk("rd_released_after_nack", sda_oe, 0);
        i2c_stop();
        @(negedge clk);
        chk("rd_busy_after_stop", busy, 0);

        // partial write byte then repeated START into a read
        tx_data = 8'h5A;
        push(EV_TXREQ, 8'h00, 1'b0);
        push(EV_STOP, 8'h00, 1'b0);
        i2c_start();
        write_byte(8'hA0, ack);
        chk("rs_addr0_ack", ack, ACK);
        clk_bit(1'b1, s);
        clk_bit(1'b0, s);
        clk_bit(1'b1, s);
        clk_bit(1'b1, s);
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rs_addr1_ack", ack, ACK);
        @(negedge clk);
        chk("rs_busy", busy, 1);
        read_byte(NACK, d);
        chk("rs_rd_byte", d, 8'h5A);
        i2c_stop();

        // reset while driving a read bit low
        tx_data = 8'h00;
        push(EV_TXREQ, 8'h00, 1'b0);
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rst_mid_addr_ack", ack, ACK);
        @(negedge clk);
        chk("rst_mid_sda_driven", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_sda_async", sda_oe, 0);
        chk("rst_mid_busy_async", busy, 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        push(EV_RX, 8'h9E, 1'b1);
        push(EV_STOP, 8'h00, 1'b0);
        i2c_start();
        write_byte(8'hA0, ack);
        chk("post_rst_addr_ack", ack, ACK);
        write_byte(8'h9E, ack);
        chk("post_rst_data_ack", ack, ACK);
        i2c_stop();

`ifdef I2C_STRETCH_EN
        // stretched fetch: tx_ready low for 20 clks after the stretch begins
        tx_data  = 8'hFF;
        tx_ready = 1'b0;
        push(EV_TXREQ, 8'h00, 1'b0);
        push(EV_STOP, 8'h00, 1'b0);
        fork
            begin
                i2c_start();
                write_byte(8'hA1, ack);
                chk("st_addr_ack", ack, ACK);
                read_byte(NACK, d);
                chk("st_rd_byte", d, 8'h3C);
            end
            begin
                int n = 0;
                int hi = 0;
                while (scl_oe !== 1'b1 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (scl_oe) hi++;
                end
                tx_data  = 8'h3C;
                tx_ready = 1'b1;
                chk("st_hold_clks", hi, 20);
            end
        join
        i2c_stop();
        @(negedge clk);
        chk("st_scl_released", scl_oe, 0);
`endif

        cyc(20);
        chk("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- I2C target (responder) side of the flash-memory bus. It answers the byte-level controller that drives SCL and shifts SDA.
- Oversamples SCL/SDA on a single system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs it, delivers written bytes to the memory logic, and serialises read bytes supplied by it.
- Drives SDA open-drain only: sda_oe=1 pulls low; 0 releases.

Parameters:
- TGT_ADDR, 7'h50, 7-bit target address compared against the address byte.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers (minimum 2).

Ports:
- clk  in  1  system clock, at least 8x SCL rate.
- rst_n  in  1  asynchronous active-low reset.
- scl_in  in  1  raw SCL from the pad.
- sda_in  in  1  raw SDA from the pad.
- sda_oe  out  1  1 = pull SDA low.
- scl_oe  out  1  1 = hold SCL low (clock stretch); constant 0 unless I2C_STRETCH_EN.
- rx_data  out  8  last received write byte, MSB first on the wire.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- rx_first  out  1  qualifies rx_valid: byte is the first after the address (the memory offset).
- tx_data  in  8  read byte, captured in the cycle tx_req=1.
- tx_req  out  1  one-cycle pulse requesting the next read byte.
- busy  out  1  1 from an address match until STOP or a non-matching START.
- stop_det  out  1  one-cycle pulse on STOP.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; synchronisers loaded with 1 (bus idle).
- Edge detection:
  - scl_rise/scl_fall come from the last two synchronised samples.
  - START = sda_s falls while scl_s=1. STOP = sda_s rises while scl_s=1.
  - START or STOP overrides every state. START goes to ADDR with the bit counter cleared. STOP goes to IDLE, pulses stop_det and releases sda_oe.
- Bit timing: SDA is sampled on scl_rise. sda_oe changes only on scl_fall, one clk after the fall is detected.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits on scl_rise. After bit 8:
    - bits[7:1]==TGT_ADDR: go to ADDR_ACK, set busy, latch rw=bit0.
    - otherwise: go to IDLE and keep SDA released.
  - ADDR_ACK: on the next scl_fall, sda_oe=1. On the following scl_fall, release.
    - rw=0: go to WR_DATA.
    - rw=1: pulse tx_req in that cycle, load shifter from tx_data, drive bit7, go to RD_DATA.
  - WR_DATA: shift 8 bits. On the 8th scl_rise, pulse rx_valid with rx_data. rx_first=1 only for the first byte of this transfer. Then go to WR_ACK.
  - WR_ACK: ACK identical to ADDR_ACK timing, then back to WR_DATA. Writes are unlimited.
  - RD_DATA: on each scl_fall, sda_oe = ~shifter[7] and shift left. After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample the controller's ACK on scl_rise.
    - ACK (0): pulse tx_req, reload, go to RD_DATA.
    - NACK (1): go to IDLE-wait and keep SDA released until STOP or START.
- Repeated START mid-byte: the partial byte is discarded, with no rx_valid and no tx_req. busy persists only if the new address matches.
- Reset mid-transfer: sda_oe and scl_oe drop asynchronously.
- Counters: 3-bit bit counter with wrap at 8 handled explicitly.

Optional Feature:
- Macro: I2C_STRETCH_EN. Adds input tx_ready.
- Enabled: in a read, at an ACK-slot scl_fall where tx_req fires and tx_ready=0, assert scl_oe.
  - Hold it until tx_ready=1, then capture tx_data and release scl_oe one clk later.
  - Bit timing resumes from the controller's next scl_rise.
- Disabled: scl_oe tied 0 and tx_data is captured unconditionally at tx_req.

Decomposition:
- Package i2c_pkg: state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK); constant BITS_PER_BYTE=8; ACK=1'b0, NACK=1'b1.
- Sub-module i2c_bus_sync: synchronisers plus scl_rise/scl_fall/start/stop detection. The top holds the FSM and shifter.

Test Plan:
- START, address 0xA0 (0x50 write), data 0x12, 0x34, STOP -> ACK in 3 slots; rx_valid twice with 0x12 (rx_first=1) then 0x34 (rx_first=0); stop_det pulses; busy falls.
- START, address 0xA2 (non-match) -> sda_oe stays 0 the whole frame; busy=0; no rx_valid.
- START, 0xA1, tx_data=0xC5, controller ACKs once then NACKs -> SDA carries 1100_0101; tx_req pulses twice; SDA released after NACK.
- Write 0xA0 and 4 bits of data, repeated START, 0xA1 -> no rx_valid for the partial byte; read proceeds with tx_req.
- rst_n low during a read while sda_oe=1 -> sda_oe=0 asynchronously; next START is decoded normally.
- With I2C_STRETCH_EN: read with tx_ready low for 20 clks -> scl_oe high for those clks; the byte transmitted is tx_data at the tx_ready rise.
